uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx.sv | 124 ++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART register layout, transmitter state encoding and frame-timing constants.
// Declarations and pure helper functions only; no clocked logic lives here.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam int unsigned BIT_TICKS     = 16;
  localparam int unsigned STOP_TICKS_1  = 16;
  localparam int unsigned STOP_TICKS_15 = 24;
  localparam int unsigned STOP_TICKS_2  = 32;

  // Line control register, LSB-aligned so integrators can wire fields straight to uart_tx.
  typedef struct packed {
    logic       dlab;
    logic       bc;
    logic       sps;
    logic       eps;
    logic       pen;
    logic       stb;
    logic [1:0] wls;
  } csr_t;

  function automatic logic [4:0] stop_last_tick(input logic stb, input logic [1:0] wls);
    if (!stb)
      return 5'(STOP_TICKS_1 - 1);
    else if (wls == 2'b00)
      return 5'(STOP_TICKS_15 - 1);
    else
      return 5'(STOP_TICKS_2 - 1);
  endfunction

  // Only the 5+wls transmitted bits take part in the XOR.
  function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] wls,
                                      input logic eps, input logic sps);
    logic [7:0] bits;
    bits = data & (8'hFF >> (2'd3 - wls));
    if (sps)
      return ~eps;
    return eps ? ^bits : ~^bits;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-fed frames of 5-8 data bits, optional parity, 1/1.5/2 stop bits; UART_TX_BREAK_EN lets bc hold the line low.
// Start bit appears on the clk edge after a non-empty FIFO is seen; the FIFO is only popped at frame boundaries, so it just waits while tx_busy.
module uart_tx (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       tx_fifo_empty,
  input  logic [7:0] tx_fifo_dout,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sps,
  input  logic       bc,
  output logic       tx_pop,
  output logic       tx,
  output logic       tx_busy,
  output logic       temt
);
  import uart_pkg::*;

  tx_state_t  state;
  logic [7:0] shift;
  logic [4:0] cnt;
  logic [2:0] bit_idx;
  logic [1:0] wls_q;
  logic       stb_q;
  logic       pen_q;
  logic       par_q;
  logic       line;
  logic       tick_last;
  logic       load;

  assign tick_last = baud_tick &&
                     (cnt == ((state == STOP) ? stop_last_tick(stb_q, wls_q) : 5'(BIT_TICKS - 1)));
  assign load      = !tx_fifo_empty && ((state == IDLE) || (state == STOP && tick_last));
  assign temt      = tx_fifo_empty & ~tx_busy;

`ifndef UART_TX_BREAK_EN
  logic unused_bc;
  assign unused_bc = bc;
`endif

  // line holds the undisturbed serial value so tx can recover it one clk after a break ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      line    <= 1'b1;
      tx      <= 1'b1;
      tx_pop  <= 1'b0;
      tx_busy <= 1'b0;
    end else begin
      tx_pop <= 1'b0;
      tx     <= line;
      if (state != IDLE && baud_tick)
        cnt <= cnt + 5'd1;
      case (state)
        IDLE: ;
        START: if (tick_last) begin
          cnt   <= '0;
          state <= DATA;
          line  <= shift[0];
          tx    <= shift[0];
        end
        DATA: if (tick_last) begin
          cnt <= '0;
          if (bit_idx == 3'd4 + {1'b0, wls_q}) begin
            state <= pen_q ? PARITY : STOP;
            line  <= pen_q ? par_q : 1'b1;
            tx    <= pen_q ? par_q : 1'b1;
          end else begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            line    <= shift[1];
            tx      <= shift[1];
          end
        end
        PARITY: if (tick_last) begin
          cnt   <= '0;
          state <= STOP;
          line  <= 1'b1;
          tx    <= 1'b1;
        end
        STOP: if (tick_last) begin
          cnt     <= '0;
          state   <= IDLE;
          tx_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          tx_busy <= 1'b0;
          line    <= 1'b1;
        end
      endcase
      // A load overrides the STOP->IDLE exit so back-to-back frames have no idle cycle.
      if (load) begin
        state   <= START;
        tx_busy <= 1'b1;
        tx_pop  <= 1'b1;
        cnt     <= '0;
        bit_idx <= '0;
        shift   <= tx_fifo_dout;
        wls_q   <= wls;
        stb_q   <= stb;
        pen_q   <= pen;
        par_q   <= parity_bit(tx_fifo_dout, wls, eps, sps);
        line    <= 1'b0;
        tx      <= 1'b0;
      end
`ifdef UART_TX_BREAK_EN
      if (bc)
        tx <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: per-tick line/busy log compared against hand-computed frame bit patterns.
module tb_uart_tx;
  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       tx_fifo_empty;
  logic [7:0] tx_fifo_dout;
  logic [1:0] wls;
  logic       stb, pen, eps, sps, bc;
  logic       tx_pop, tx, tx_busy, temt;

  int checks = 0;
  int errors = 0;
  int pops;
  int pop_bad;
  int div;
  int brk_on  = -1;
  int brk_off = -1;
  bit cap = 0;
  logic [7:0] fifo_q[$];
  logic [1:0] log_q[$];
  logic       exp_q[$];

  uart_tx dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_dout(tx_fifo_dout), .wls(wls), .stb(stb), .pen(pen), .eps(eps), .sps(sps),
    .bc(bc), .tx_pop(tx_pop), .tx(tx), .tx_busy(tx_busy), .temt(temt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // FWFT FIFO model, baud tick every third clk, and per-tick {busy, tx} capture.
  initial begin
    div = 0; pops = 0; pop_bad = 0;
    baud_tick = 0; bc = 0; tx_fifo_empty = 1; tx_fifo_dout = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_pop === 1'b1) begin
        pops++;
        if (fifo_q.size() == 0) pop_bad++;
        else void'(fifo_q.pop_front());
      end
      div = (div == 2) ? 0 : div + 1;
      baud_tick = (div == 0);
      if (baud_tick && cap) begin
        log_q.push_back({tx_busy, tx});
        if (log_q.size() - 1 == brk_on)  bc = 1'b1;
        if (log_q.size() - 1 == brk_off) bc = 1'b0;
      end
      tx_fifo_empty = (fifo_q.size() == 0);
      tx_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    end
  end

  task automatic set_lcr(input logic [1:0] w, input logic s_b, input logic p, input logic e, input logic sp);
    wls = w; stb = s_b; pen = p; eps = e; sps = sp;
  endtask

  task automatic start_capture();
    log_q.delete(); exp_q.delete(); pops = 0; pop_bad = 0; cap = 1;
  endtask

  // bits[0] is the start bit; each listed bit lasts 16 ticks, followed by stop ticks of 1.
  task automatic expect_frame(input logic [11:0] bits, input int nbits, input int stop);
    for (int i = 0; i < nbits; i++)
      for (int t = 0; t < 16; t++) exp_q.push_back(bits[i]);
    for (int t = 0; t < stop; t++) exp_q.push_back(1'b1);
  endtask

  task automatic wait_start(output int s);
    s = -1;
    for (int n = 0; n < 300 && s < 0; n++) begin
      @(negedge clk); #1;
      foreach (log_q[i]) if (s < 0 && log_q[i][0] == 1'b0) s = i;
    end
    if (s < 0) begin
      checks++; errors++;
      $display("FAIL start_timeout: no start bit seen, required within 300 clks");
      s = 0;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy !== 1'b0 || fifo_q.size() != 0) && n < 3000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: tx_busy=%b still set, required 0 within 3000 clks", tx_busy);
    end
    repeat (30) @(negedge clk);
    #1; cap = 0;
  endtask

  function automatic void score(input int s, output int tx_bad, output int busy_bad, output logic end_busy);
    tx_bad = 0; busy_bad = 0; end_busy = 1'bx;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (s + k >= log_q.size()) begin
        tx_bad++; busy_bad++;
      end else begin
        if (log_q[s+k][0] !== exp_q[k]) tx_bad++;
        if (log_q[s+k][1] !== 1'b1)     busy_bad++;
      end
    end
    if (s + exp_q.size() < log_q.size()) end_busy = log_q[s + exp_q.size()][1];
  endfunction

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk); #1;
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx actual=%b required=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b required=0", tx_busy); end
    checks++; if (tx_pop !== 1'b0)  begin errors++; $display("FAIL reset_pop actual=%b required=0", tx_pop); end
    checks++; if (temt !== 1'b1)    begin errors++; $display("FAIL reset_temt_empty actual=%b required=1", temt); end
    fifo_q.push_back(8'h99);
    repeat (3) @(negedge clk); #1;
    checks++; if (temt !== 1'b0) begin errors++; $display("FAIL reset_temt_full actual=%b required=0", temt); end
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_pop !== 1'b0) begin
      errors++; $display("FAIL reset_hold tx/busy/pop actual=%b%b%b required=100", tx, tx_busy, tx_pop);
    end
    fifo_q.delete();
    @(negedge clk); #1;
    rst = 1;
    repeat (3) @(negedge clk); #1;
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset tx/busy actual=%b%b required=10", tx, tx_busy);
    end
  endtask

  task automatic test_8n1();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b11, 0, 0, 0, 0);
    start_capture(); expect_frame(12'h0AA, 9, 16);
    fifo_q.push_back(8'h55);
    wait_start(s); wait_idle();
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0) begin errors++; $display("FAIL 8n1_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (bb_bad !== 0) begin errors++; $display("FAIL 8n1_busy bad_ticks=%0d required=0", bb_bad); end
    checks++; if (eb !== 1'b0)  begin errors++; $display("FAIL 8n1_stop_end busy=%b required=0", eb); end
    checks++; if (pops !== 1)   begin errors++; $display("FAIL 8n1_pops actual=%0d required=1", pops); end
  endtask

  task automatic test_7e2_lcr_hold();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b10, 1, 1, 1, 0);
    start_capture(); expect_frame(12'h082, 9, 32);
    fifo_q.push_back(8'h41);
    wait_start(s);
    set_lcr(2'b00, 0, 0, 0, 1);
    wait_idle();
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0) begin errors++; $display("FAIL 7e2_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (bb_bad !== 0) begin errors++; $display("FAIL 7e2_busy bad_ticks=%0d required=0", bb_bad); end
    checks++; if (eb !== 1'b0)  begin errors++; $display("FAIL 7e2_stop32_end busy=%b required=0", eb); end
  endtask

  task automatic test_6o1_mask();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b01, 0, 1, 0, 0);
    start_capture(); expect_frame(12'h086, 8, 16);
    fifo_q.push_back(8'h43);
    wait_start(s); wait_idle();
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0) begin errors++; $display("FAIL 6o1_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (eb !== 1'b0)  begin errors++; $display("FAIL 6o1_stop_end busy=%b required=0", eb); end
  endtask

  task automatic test_5bit_stick();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b00, 1, 1, 0, 1);
    start_capture(); expect_frame(12'h07E, 7, 24);
    fifo_q.push_back(8'h1F);
    wait_start(s); wait_idle();
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0) begin errors++; $display("FAIL 5s_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (bb_bad !== 0) begin errors++; $display("FAIL 5s_busy bad_ticks=%0d required=0", bb_bad); end
    checks++; if (eb !== 1'b0)  begin errors++; $display("FAIL 5s_stop24_end busy=%b required=0", eb); end
  endtask

  task automatic test_back_to_back();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b11, 0, 0, 0, 0);
    start_capture(); expect_frame(12'h14A, 9, 16); expect_frame(12'h078, 9, 16);
    fifo_q.push_back(8'hA5); fifo_q.push_back(8'h3C);
    wait_start(s); wait_idle();
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0)  begin errors++; $display("FAIL b2b_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (bb_bad !== 0)  begin errors++; $display("FAIL b2b_busy_gap bad_ticks=%0d required=0", bb_bad); end
    checks++; if (eb !== 1'b0)   begin errors++; $display("FAIL b2b_end busy=%b required=0", eb); end
    checks++; if (pops !== 2)    begin errors++; $display("FAIL b2b_pops actual=%0d required=2", pops); end
    checks++; if (pop_bad !== 0) begin errors++; $display("FAIL b2b_pop_empty actual=%0d required=0", pop_bad); end
    checks++; if (temt !== 1'b1) begin errors++; $display("FAIL b2b_temt actual=%b required=1", temt); end
  endtask

  task automatic test_break();
    int s, tb_bad, bb_bad; logic eb;
    set_lcr(2'b11, 0, 0, 0, 0);
    start_capture(); expect_frame(12'h1FE, 9, 16);
`ifdef UART_TX_BREAK_EN
    for (int k = 41; k <= 90; k++) exp_q[k] = 1'b0;
`endif
    fifo_q.push_back(8'hFF);
    wait_start(s);
    brk_on = s + 40; brk_off = s + 90;
    wait_idle();
    brk_on = -1; brk_off = -1;
    score(s, tb_bad, bb_bad, eb);
    checks++; if (tb_bad !== 0) begin errors++; $display("FAIL brk_line bad_ticks=%0d required=0", tb_bad); end
    checks++; if (bb_bad !== 0) begin errors++; $display("FAIL brk_busy bad_ticks=%0d required=0", bb_bad); end
    checks++; if (eb !== 1'b0)  begin errors++; $display("FAIL brk_end busy=%b required=0", eb); end
  endtask

  task automatic test_reset_midframe();
    int s;
    set_lcr(2'b11, 0, 0, 0, 0);
    start_capture();
    fifo_q.push_back(8'h55);
    wait_start(s);
    repeat (110) @(negedge clk); #1;
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx actual=%b required=0", tx); end
    rst = 0; #1;
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL mid_rst_tx actual=%b required=1", tx); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy actual=%b required=0", tx_busy); end
    checks++; if (tx_pop !== 1'b0)  begin errors++; $display("FAIL mid_rst_pop actual=%b required=0", tx_pop); end
    checks++; if (temt !== 1'b1)    begin errors++; $display("FAIL mid_rst_temt actual=%b required=1", temt); end
    repeat (2) @(negedge clk); #1;
    rst = 1; cap = 0;
    repeat (60) @(negedge clk); #1;
    checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL mid_post_idle tx/busy actual=%b%b required=10", tx, tx_busy);
    end
  endtask

  initial begin
    rst = 0;
    set_lcr(2'b11, 0, 0, 0, 0);
    test_reset();
    test_8n1();
    test_7e2_lcr_hold();
    test_6o1_mask();
    test_5bit_stick();
    test_back_to_back();
    test_break();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
